// File: rtl/bus_master_if_pkg.sv
// Shared definitions for the serial bus master: FSM states, default widths
// and the acknowledge timeout also used by the bus-level testbench.
package bus_master_if_pkg;

    typedef enum logic [3:0] {
        IDLE       = 4'd0,
        REQ        = 4'd1,
        SEND_DEV   = 4'd2,
        WAIT_ACK   = 4'd3,
        SEND_ADDR  = 4'd4,
        SEND_DATA  = 4'd5,
        WAIT_RDATA = 4'd6,
        SPLIT_WAIT = 4'd7,
        DONE       = 4'd8
    } state_t;

    localparam int DEF_ADDR_WIDTH        = 16;
    localparam int DEF_DATA_WIDTH        = 8;
    localparam int DEF_DEVICE_ADDR_WIDTH = 4;
    localparam int DEF_ACK_TIMEOUT       = 16;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Bit counter must reach the longest serial field and still hold one more.
    function automatic int cnt_width(input int aw, input int dw);
        return $clog2(max_int(aw, dw)) + 1;
    endfunction

endpackage

// File: rtl/bus_master_if_piso_sipo_shift.sv
// Shared shifter: parallel-in/serial-out for address and write data,
// serial-in/parallel-out for read data, one bit counter for both.
module piso_sipo_shift #(
    parameter int SW = 16,
    parameter int RW = 8,
    parameter int CW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          clr,
    input  logic          shift,
    input  logic          sin_en,
    input  logic          sin,
    input  logic [SW-1:0] par_in,
    output logic          sout,
    output logic [CW-1:0] cnt,
    output logic [RW-1:0] rx_merged
);

    logic [SW-1:0] sh_r;
    logic [RW-1:0] rx_r;
    logic [CW-1:0] cnt_r;

    // Receive word with the incoming bit placed at the current count position.
    always_comb begin
        rx_merged = rx_r;
        for (int i = 0; i < RW; i++) begin
            if (cnt_r == CW'(i)) begin
                rx_merged[i] = sin;
            end else begin
                rx_merged[i] = rx_r[i];
            end
        end
    end

    // Shift, capture and count; load also clears the receive word.
    always_ff @(posedge clk) begin
        if (rst) begin
            sh_r  <= '0;
            rx_r  <= '0;
            cnt_r <= '0;
        end else if (load) begin
            sh_r  <= par_in;
            rx_r  <= '0;
            cnt_r <= '0;
        end else if (clr) begin
            sh_r  <= '0;
            cnt_r <= '0;
        end else if (shift) begin
            sh_r  <= {1'b0, sh_r[SW-1:1]};
            cnt_r <= cnt_r + CW'(1);
        end else if (sin_en) begin
            rx_r  <= rx_merged;
            cnt_r <= cnt_r + CW'(1);
        end
    end

    // The shift register LSB is the serial line, so it is a flop output and
    // reads zero whenever nothing is being sent.
    assign sout = sh_r[0];
    assign cnt  = cnt_r;

endmodule

// File: rtl/bus_master_if.sv
// Serial bus master: arbitrates for the bus, sends device select, address
// and write data LSB first, and collects serial read data with split support.
module bus_master_if
    import bus_master_if_pkg::*;
#(
    parameter int ADDR_WIDTH        = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH        = DEF_DATA_WIDTH,
    parameter int DEVICE_ADDR_WIDTH = DEF_DEVICE_ADDR_WIDTH,
    parameter int ACK_TIMEOUT       = DEF_ACK_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic                  wr,
    input  logic [DATA_WIDTH-1:0] wdata_in,
    output logic [DATA_WIDTH-1:0] rdata_out,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic                  bus_breq,
    input  logic                  bus_bgrant,
    output logic                  bus_wdata,
    output logic                  bus_mode,
    output logic                  bus_mvalid,
    input  logic                  bus_ack,
    input  logic                  bus_split,
    input  logic                  bus_rdata,
    input  logic                  bus_svalid
);

    localparam int SW = max_int(ADDR_WIDTH, DATA_WIDTH);
    localparam int CW = cnt_width(ADDR_WIDTH, DATA_WIDTH);
    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    localparam int LW = ADDR_WIDTH - DEVICE_ADDR_WIDTH;

    state_t                  state_r;
    state_t                  nxt_s;
    logic                    err_s;
    logic                    rd_ok_s;
    logic [ADDR_WIDTH-1:0]   addr_r;
    logic                    wr_r;
    logic [DATA_WIDTH-1:0]   wdata_r;
    logic [TW-1:0]           tmo_r;
    logic                    load_s;
    logic                    clr_s;
    logic                    shift_s;
    logic                    sin_en_s;
    logic [SW-1:0]           par_s;
    logic [CW-1:0]           cnt_s;
    logic [DATA_WIDTH-1:0]   rx_merged_s;

    // Next-state decode; split takes priority over grant loss while reading.
    always_comb begin
        nxt_s   = state_r;
        err_s   = 1'b0;
        rd_ok_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (req) nxt_s = REQ;
                else     nxt_s = IDLE;
            end
            REQ: begin
                if (bus_bgrant) nxt_s = SEND_DEV;
                else            nxt_s = REQ;
            end
            SEND_DEV: begin
                if (!bus_bgrant) begin
                    nxt_s = DONE;
                    err_s = 1'b1;
                end else if (cnt_s == CW'(DEVICE_ADDR_WIDTH - 1)) begin
                    nxt_s = WAIT_ACK;
                end else begin
                    nxt_s = SEND_DEV;
                end
            end
            WAIT_ACK: begin
                if (!bus_bgrant) begin
                    nxt_s = DONE;
                    err_s = 1'b1;
                end else if (bus_ack) begin
                    nxt_s = SEND_ADDR;
                end else if (tmo_r == TW'(ACK_TIMEOUT - 1)) begin
                    nxt_s = DONE;
                    err_s = 1'b1;
                end else begin
                    nxt_s = WAIT_ACK;
                end
            end
            SEND_ADDR: begin
                if (!bus_bgrant) begin
                    nxt_s = DONE;
                    err_s = 1'b1;
                end else if (cnt_s == CW'(LW - 1)) begin
                    nxt_s = wr_r ? SEND_DATA : WAIT_RDATA;
                end else begin
                    nxt_s = SEND_ADDR;
                end
            end
            SEND_DATA: begin
                if (!bus_bgrant) begin
                    nxt_s = DONE;
                    err_s = 1'b1;
                end else if (cnt_s == CW'(DATA_WIDTH - 1)) begin
                    nxt_s = DONE;
                end else begin
                    nxt_s = SEND_DATA;
                end
            end
            WAIT_RDATA: begin
                if (bus_split) begin
                    nxt_s = SPLIT_WAIT;
                end else if (!bus_bgrant) begin
                    nxt_s = DONE;
                    err_s = 1'b1;
                end else if (bus_svalid && (cnt_s == CW'(DATA_WIDTH - 1))) begin
                    nxt_s   = DONE;
                    rd_ok_s = 1'b1;
                end else begin
                    nxt_s = WAIT_RDATA;
                end
            end
            SPLIT_WAIT: begin
                if (!bus_split && bus_bgrant) nxt_s = WAIT_RDATA;
                else                          nxt_s = SPLIT_WAIT;
            end
            DONE:    nxt_s = IDLE;
            default: nxt_s = IDLE;
        endcase
    end

    // Shifter control: load/clear on state entry, except that a split
    // suspends and resumes the read without losing the received bits.
    always_comb begin
        load_s   = 1'b0;
        clr_s    = 1'b0;
        shift_s  = 1'b0;
        sin_en_s = 1'b0;
        par_s    = '0;
        if (nxt_s != state_r) begin
            case (nxt_s)
                SEND_DEV: begin
                    load_s = 1'b1;
                    par_s  = SW'(addr_r[ADDR_WIDTH-1 -: DEVICE_ADDR_WIDTH]);
                end
                SEND_ADDR: begin
                    load_s = 1'b1;
                    par_s  = SW'(addr_r[LW-1:0]);
                end
                SEND_DATA: begin
                    load_s = 1'b1;
                    par_s  = SW'(wdata_r);
                end
                WAIT_RDATA: begin
                    if (state_r != SPLIT_WAIT) load_s = 1'b1;
                    else                       load_s = 1'b0;
                end
                SPLIT_WAIT: clr_s = 1'b0;
                default:    clr_s = 1'b1;
            endcase
        end else begin
            shift_s  = (state_r == SEND_DEV) || (state_r == SEND_ADDR) ||
                       (state_r == SEND_DATA);
            sin_en_s = (state_r == WAIT_RDATA) && bus_svalid;
        end
    end

    // Main FSM: state, request latches, timeout counter and all outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            addr_r     <= '0;
            wr_r       <= 1'b0;
            wdata_r    <= '0;
            tmo_r      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            bus_breq   <= 1'b0;
            bus_mvalid <= 1'b0;
            bus_mode   <= 1'b0;
            rdata_out  <= '0;
        end else begin
            state_r    <= nxt_s;
            busy       <= (nxt_s != IDLE);
            done       <= (nxt_s == DONE);
            err        <= err_s;
            bus_breq   <= (nxt_s != IDLE) && (nxt_s != DONE);
            bus_mvalid <= (nxt_s == SEND_DEV) || (nxt_s == SEND_ADDR) ||
                          (nxt_s == SEND_DATA);
            if (state_r == IDLE && req) begin
                addr_r  <= addr;
                wr_r    <= wr;
                wdata_r <= wdata_in;
            end
            if (nxt_s == IDLE)        bus_mode <= 1'b0;
            else if (state_r == IDLE) bus_mode <= wr;
            else                      bus_mode <= wr_r;
            if (state_r == WAIT_ACK && nxt_s == WAIT_ACK) tmo_r <= tmo_r + TW'(1);
            else                                          tmo_r <= '0;
            if (rd_ok_s) rdata_out <= rx_merged_s;
        end
    end

    piso_sipo_shift #(
        .SW (SW),
        .RW (DATA_WIDTH),
        .CW (CW)
    ) u_shift (
        .clk       (clk),
        .rst       (rst),
        .load      (load_s),
        .clr       (clr_s),
        .shift     (shift_s),
        .sin_en    (sin_en_s),
        .sin       (bus_rdata),
        .par_in    (par_s),
        .sout      (bus_wdata),
        .cnt       (cnt_s),
        .rx_merged (rx_merged_s)
    );

endmodule

// File: tb/tb_bus_master_if.sv
// Directed bench for bus_master_if: serial bits and read words are predicted
// into scoreboard queues and compared as the master produces them.
module tb_bus_master_if;
    import bus_master_if_pkg::*;

    logic        clk = 1'b0;
    logic        rst, req, wr, bus_bgrant, bus_ack, bus_split, bus_rdata, bus_svalid;
    logic [15:0] addr;
    logic [7:0]  wdata_in, rdata_out;
    logic        busy, done, err, bus_breq, bus_wdata, bus_mode, bus_mvalid;

    int          checks = 0;
    int          errors = 0;
    logic        exp_q[$];
    logic [7:0]  rd_q[$];
    logic        cur_wr = 1'b0;
    logic [7:0]  last_rd = 8'h00;
    int          n;

    bus_master_if dut (
        .clk(clk), .rst(rst), .req(req), .addr(addr), .wr(wr), .wdata_in(wdata_in),
        .rdata_out(rdata_out), .busy(busy), .done(done), .err(err),
        .bus_breq(bus_breq), .bus_bgrant(bus_bgrant), .bus_wdata(bus_wdata),
        .bus_mode(bus_mode), .bus_mvalid(bus_mvalid), .bus_ack(bus_ack),
        .bus_split(bus_split), .bus_rdata(bus_rdata), .bus_svalid(bus_svalid)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push_bits(input logic [31:0] v, input int nb);
        for (int i = 0; i < nb; i++) exp_q.push_back(v[i]);
    endtask

    // One clock; outputs sampled 1 time unit after the edge, serial line scored.
    task automatic tick();
        logic e;
        @(posedge clk);
        #1;
        if (bus_mvalid) begin
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("ser_bit", bus_wdata, e);
            end else begin
                chk("ser_extra", bus_mvalid, 1'b0);
            end
        end else begin
            chk("wdata_gate", bus_wdata, 1'b0);
        end
        if (busy) chk("mode_busy", bus_mode, cur_wr);
        else      chk("mode_idle", bus_mode, 1'b0);
    endtask

    task automatic start(input logic [15:0] a, input logic w, input logic [7:0] d);
        addr = a; wr = w; wdata_in = d; req = 1'b1; cur_wr = w;
        tick();
        req = 1'b0;
        chk("start_busy", busy, 1'b1);
        chk("start_breq", bus_breq, 1'b1);
    endtask

    task automatic wait_q(input int lvl, input int budget, input string tag);
        int k = 0;
        while (exp_q.size() > lvl && k < budget) begin tick(); k++; end
        chk(tag, exp_q.size() <= lvl, 1'b1);
    endtask

    task automatic wait_bus_quiet(input int budget, input string tag);
        int k = 0;
        while (!(exp_q.size() == 0 && !bus_mvalid) && k < budget) begin tick(); k++; end
        chk(tag, (exp_q.size() == 0) && !bus_mvalid, 1'b1);
    endtask

    task automatic wait_done(input int budget, input string tag, output int cyc);
        cyc = 0;
        while (!done && cyc < budget) begin tick(); cyc++; end
        chk(tag, done, 1'b1);
    endtask

    // Slave returns v LSB first, with an optional 2-cycle svalid gap or a
    // 10-cycle split before bit index gap_at / split_at.
    task automatic read_bits(input logic [7:0] v, input int gap_at, input int split_at);
        logic [7:0] e;
        for (int i = 0; i < 8; i++) begin
            if (i == gap_at) begin
                bus_svalid = 1'b0;
                repeat (2) tick();
                chk("gap_no_done", done, 1'b0);
            end
            if (i == split_at) begin
                bus_svalid = 1'b0; bus_split = 1'b1; bus_bgrant = 1'b0;
                for (int k = 0; k < 10; k++) begin
                    tick();
                    chk("split_breq", bus_breq, 1'b1);
                    chk("split_mvalid", bus_mvalid, 1'b0);
                end
                bus_split = 1'b0; bus_bgrant = 1'b1;
                tick();
                chk("resume_breq", bus_breq, 1'b1);
            end
            bus_rdata = v[i]; bus_svalid = 1'b1;
            tick();
        end
        bus_svalid = 1'b0; bus_rdata = 1'b0;
        chk("rd_done", done, 1'b1);
        chk("rd_err", err, 1'b0);
        e = rd_q.pop_front();
        chk("rd_data", rdata_out, e);
        last_rd = e;
    endtask

    initial begin
        rst = 1'b1; req = 1'b0; wr = 1'b0; addr = 16'h0000; wdata_in = 8'h00;
        bus_bgrant = 1'b0; bus_ack = 1'b0; bus_split = 1'b0;
        bus_rdata = 1'b0; bus_svalid = 1'b0;
        repeat (3) tick();
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_breq", bus_breq, 1'b0);
        chk("rst_mvalid", bus_mvalid, 1'b0);
        chk("rst_rdata", rdata_out, 8'h00);
        rst = 1'b0;
        tick();

        // Write 0x2ABC / 0x5A; a second req while busy is ignored.
        push_bits(32'h2, 4); push_bits(32'hABC, 12); push_bits(32'h5A, 8);
        start(16'h2ABC, 1'b1, 8'h5A);
        addr = 16'hFFFF; wr = 1'b0; wdata_in = 8'hFF; req = 1'b1;
        tick();
        req = 1'b0;
        chk("req_wait_mvalid", bus_mvalid, 1'b0);
        bus_bgrant = 1'b1; bus_ack = 1'b1;
        wait_done(60, "wr_done", n);
        chk("wr_err", err, 1'b0);
        chk("wr_done_breq", bus_breq, 1'b0);
        chk("wr_done_busy", busy, 1'b1);
        chk("wr_all_bits", exp_q.size(), 0);
        chk("wr_rdata_keep", rdata_out, last_rd);
        bus_bgrant = 1'b0; bus_ack = 1'b0;
        tick();
        chk("wr_pulse_end", done, 1'b0);
        chk("wr_idle_busy", busy, 1'b0);

        // Read 0x1010 returning 0xC3 with an svalid gap.
        push_bits(32'h1, 4); push_bits(32'h010, 12); rd_q.push_back(8'hC3);
        start(16'h1010, 1'b0, 8'h00);
        bus_bgrant = 1'b1; bus_ack = 1'b1;
        wait_bus_quiet(40, "rd1_addr_sent");
        read_bits(8'hC3, 5, -1);
        bus_bgrant = 1'b0; bus_ack = 1'b0;
        tick();

        // Read 0x2004 returning 0x96 with a 10-cycle split after 3 bits.
        push_bits(32'h2, 4); push_bits(32'h004, 12); rd_q.push_back(8'h96);
        start(16'h2004, 1'b0, 8'h00);
        bus_bgrant = 1'b1; bus_ack = 1'b1;
        wait_bus_quiet(40, "rd2_addr_sent");
        read_bits(8'h96, -1, 3);
        bus_bgrant = 1'b0; bus_ack = 1'b0;
        tick();

        // No ack: timeout counted from the first WAIT_ACK cycle.
        push_bits(32'h3, 4);
        start(16'h3456, 1'b0, 8'h00);
        bus_bgrant = 1'b1;
        wait_bus_quiet(20, "tmo_dev_sent");
        wait_done(40, "tmo_done", n);
        chk("tmo_cycles", n, DEF_ACK_TIMEOUT);
        chk("tmo_err", err, 1'b1);
        chk("tmo_rdata_keep", rdata_out, last_rd);
        bus_bgrant = 1'b0;
        tick();

        // Reset in the middle of SEND_ADDR, then a clean write.
        push_bits(32'h4, 4); push_bits(32'h321, 12); push_bits(32'h77, 8);
        start(16'h4321, 1'b1, 8'h77);
        bus_bgrant = 1'b1; bus_ack = 1'b1;
        wait_q(17, 40, "rst_reach_addr");
        rst = 1'b1;
        tick();
        chk("mid_rst_breq", bus_breq, 1'b0);
        chk("mid_rst_mvalid", bus_mvalid, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_rdata", rdata_out, 8'h00);
        last_rd = 8'h00;
        rst = 1'b0; bus_bgrant = 1'b0; bus_ack = 1'b0;
        exp_q.delete();
        tick();
        push_bits(32'h3, 4); push_bits(32'h155, 12); push_bits(32'hA7, 8);
        start(16'h3155, 1'b1, 8'hA7);
        bus_bgrant = 1'b1; bus_ack = 1'b1;
        wait_done(60, "post_rst_done", n);
        chk("post_rst_err", err, 1'b0);
        chk("post_rst_bits", exp_q.size(), 0);
        bus_bgrant = 1'b0; bus_ack = 1'b0;
        tick();

        // Grant lost during SEND_DATA.
        push_bits(32'h1, 4); push_bits(32'h234, 12); push_bits(32'hF0, 8);
        start(16'h1234, 1'b1, 8'hF0);
        bus_bgrant = 1'b1; bus_ack = 1'b1;
        wait_q(5, 60, "gl_reach_data");
        bus_bgrant = 1'b0;
        tick();
        chk("gl_done", done, 1'b1);
        chk("gl_err", err, 1'b1);
        chk("gl_breq", bus_breq, 1'b0);
        chk("gl_mvalid", bus_mvalid, 1'b0);
        chk("gl_rdata_keep", rdata_out, last_rd);
        exp_q.delete();
        bus_ack = 1'b0;
        tick();
        chk("gl_idle_busy", busy, 1'b0);
        chk("gl_idle_err", err, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
